lcd_receiver: RTL and testbench
===============================

LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 40, giving the busy duration in clk cycles after each accepted write.
REQ-002 SHALL have these ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- lcd_e  in  1  bus enable; asynchronous to clk.
- lcd_rs  in  1  register select: 0 = instruction, 1 = data.
- lcd_rw  in  1  direction: 0 = write, 1 = read.
- lcd_data_in  in  8  bus write data.
- lcd_data_out  out  8  bus read data.
- lcd_data_oe  out  1  read-data drive enable.
- rd_addr  in  5  display-buffer peek index, 0-31.
- rd_char  out  8  buffer[rd_addr], combinational.
- cursor  out  7  current DDRAM address.
- disp_on  out  1  display-on flag.
- entry_inc  out  1  1 = increment address after data access, 0 = decrement.
- two_line  out  1  set by function-set bit 3.
- cmd_drop  out  1  one-cycle pulse when a transaction is discarded.

Function
REQ-003 SHALL synchronize lcd_e through two flops and form a one-cycle strobe on its falling edge.
- lcd_rs, lcd_rw and lcd_data_in are sampled on that strobe.
- The effect is visible on outputs 3 clk after lcd_e falls.
REQ-004 SHALL hold a 32-byte display buffer as a flop array.
- Index 0-15 maps to DDRAM 0x00-0x0F; index 16-31 maps to 0x40-0x4F.
- Writes to any other DDRAM address are discarded without error.
REQ-005 SHALL decode instructions (rs=0, rw=0) by their highest set bit:
- 0x01 clear: enter CLEARING; address = 0; entry_inc = 1.
- 0x02/0x03 home: address = 0.
- 0b000001xx entry mode: entry_inc = bit 1; shift bit ignored.
- 0b00001xxx display control: disp_on = bit 2.
- 0b0001xxxx shift: ignored.
- 0b001xxxxx function set: two_line = bit 3.
- 0b01xxxxxx CGRAM address: ignored.
- 0b1xxxxxxx DDRAM address: address = data[6:0].
- 0x00: ignored.
REQ-006 SHALL handle a data write (rs=1, rw=0) by storing the byte at the mapped index (if valid), then stepping the address per entry_inc.
REQ-007 SHALL step the address as follows:
- two_line=1: increment wraps 0x27->0x40 and 0x67->0x00; decrement wraps in reverse.
- two_line=0: the address wraps modulo 0x50.
REQ-008 SHALL handle reads while synchronized lcd_e=1 and lcd_rw=1:
- lcd_data_oe = 1.
- rs=0: lcd_data_out = {busy, address}.
- rs=1: lcd_data_out = buffer byte at the address (0x20 if unmapped), and the address steps on the falling-edge strobe.
REQ-009 SHALL otherwise drive lcd_data_oe = 0 and lcd_data_out = 0.
REQ-010 SHALL implement states IDLE, CLEARING and BUSY:
- IDLE -> CLEARING on a clear instruction.
- CLEARING writes 0x20 to one index per clk, 0 to 31, then goes to BUSY (macro on) or IDLE (macro off).
- IDLE -> BUSY on any other accepted write when the macro is on.
- BUSY -> IDLE after BUSY_CYCLES clk.
REQ-011 SHALL discard any write strobe arriving in CLEARING or BUSY and pulse cmd_drop for one clk; reads are always serviced.
REQ-012 SHALL report busy = 1 in CLEARING and BUSY, and 0 otherwise.
REQ-013 SHALL give rst priority when it coincides with a strobe; the transaction is lost and cmd_drop stays 0.

Reset
REQ-014 SHALL, on rst=1 at a clk edge, set all of the following in that one cycle:
- buffer = 0x20 in all 32 entries.
- address = 0; entry_inc = 1; disp_on = 0; two_line = 0.
- state IDLE; busy counter = 0.
- lcd_data_oe = 0; lcd_data_out = 0; cmd_drop = 0; edge synchronizer = 0.
REQ-015 SHALL, when rst is asserted mid-CLEARING or mid-BUSY, abort the operation and leave the block in its full reset state.

Configuration
REQ-016 SHALL, when LCD_RX_BUSY_EN is defined, implement the BUSY state and the BUSY_CYCLES counter.
REQ-017 SHALL, when LCD_RX_BUSY_EN is undefined, omit the BUSY state and counter:
- The busy bit is 1 only during CLEARING.
- cmd_drop fires only for strobes arriving during CLEARING.

Verification
REQ-018 SHALL cover: instruction 0x80, then data 0x48 and 0x69 -> rd_char[0]=0x48, rd_char[1]=0x69, cursor=0x02.
REQ-019 SHALL cover: two_line=1, address 0x27, data 0x41 -> write discarded, cursor=0x40; next data 0x42 -> rd_char[16]=0x42.
REQ-020 SHALL cover: buffer filled, clear instruction, write strobe 5 clk later -> cmd_drop pulses once; after 32 clk all rd_char=0x20 and cursor=0.
REQ-021 SHALL cover (macro on, BUSY_CYCLES=40): data write, then status read at +10 clk -> lcd_data_out[7]=1; at +45 clk -> 0.
REQ-022 SHALL cover: entry mode 0x04, address 0x40, data 0x5A -> rd_char[16]=0x5A, cursor=0x27.
REQ-023 SHALL cover: rst asserted during CLEARING at index 12 -> all outputs at reset values and buffer all 0x20 on the next clk.

Source files
------------

// File: rtl/lcd_receiver.sv
// HD44780-style LCD bus slave mirroring a 2x16 display buffer.
// Define LCD_RX_BUSY_EN to add the post-write BUSY state timed by BUSY_CYCLES.
module lcd_receiver #(
  parameter int BUSY_CYCLES = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor,
  output logic       disp_on,
  output logic       entry_inc,
  output logic       two_line,
  output logic       cmd_drop
);

  typedef enum logic [1:0] {IDLE, CLEARING, BUSY} state_t;

  state_t     state;
  logic       e_s1, e_s2, e_s3;
  logic       strobe;
  logic       busy;
  logic       rd_active;
  logic [7:0] buffer [32];
  logic [6:0] address;
  logic [4:0] clr_idx;
  logic [5:0] cur_map;
  logic [7:0] cur_byte;

`ifdef LCD_RX_BUSY_EN
  localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  logic [CW-1:0] busy_cnt;
`else
  if (BUSY_CYCLES < 0) begin : g_busy_cycles_unused
  end
`endif

  // {valid, index}: 0x00-0x0F -> 0-15, 0x40-0x4F -> 16-31
  function automatic logic [5:0] map_addr(input logic [6:0] a);
    if (a[6:4] == 3'd0) return {2'b10, a[3:0]};
    if (a[6:4] == 3'd4) return {2'b11, a[3:0]};
    return 6'd0;
  endfunction

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc, input logic two);
    if (two) begin
      if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      return (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
    end
    // single-line: modulo 0x50, also folding addresses set above 0x4F
    if (inc) return (a >= 7'h4F) ? a - 7'h4F : a + 7'd1;
    return (a == 7'h00) ? 7'h4F : (a > 7'h50) ? a - 7'h51 : a - 7'd1;
  endfunction

  assign strobe    = e_s3 & ~e_s2;
  assign busy      = (state != IDLE);
  assign rd_active = e_s2 & lcd_rw;
  assign cur_map   = map_addr(address);
  assign cur_byte  = cur_map[5] ? buffer[cur_map[4:0]] : 8'h20;
  assign rd_char   = buffer[rd_addr];
  assign cursor    = address;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
      address      <= 7'd0;
      entry_inc    <= 1'b1;
      disp_on      <= 1'b0;
      two_line     <= 1'b0;
      state        <= IDLE;
      clr_idx      <= 5'd0;
`ifdef LCD_RX_BUSY_EN
      busy_cnt     <= '0;
`endif
      lcd_data_oe  <= 1'b0;
      lcd_data_out <= 8'h00;
      cmd_drop     <= 1'b0;
      e_s1         <= 1'b0;
      e_s2         <= 1'b0;
      e_s3         <= 1'b0;
    end else begin
      e_s1         <= lcd_e;
      e_s2         <= e_s1;
      e_s3         <= e_s2;
      cmd_drop     <= 1'b0;
      lcd_data_oe  <= rd_active;
      lcd_data_out <= !rd_active ? 8'h00 : lcd_rs ? cur_byte : {busy, address};

      case (state)
        CLEARING: begin
          buffer[clr_idx] <= 8'h20;
          clr_idx         <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) begin
`ifdef LCD_RX_BUSY_EN
            state    <= BUSY;
            busy_cnt <= CW'(BUSY_CYCLES - 1);
`else
            state    <= IDLE;
`endif
          end
        end
`ifdef LCD_RX_BUSY_EN
        BUSY: begin
          if (busy_cnt == '0) state <= IDLE;
          else                busy_cnt <= busy_cnt - CW'(1);
        end
`endif
        default: ;
      endcase

      if (strobe) begin
        if (lcd_rw) begin
          if (lcd_rs) address <= step_addr(address, entry_inc, two_line);
        end else if (state != IDLE) begin
          cmd_drop <= 1'b1;
        end else if (lcd_rs) begin
          if (cur_map[5]) buffer[cur_map[4:0]] <= lcd_data_in;
          address <= step_addr(address, entry_inc, two_line);
`ifdef LCD_RX_BUSY_EN
          state    <= BUSY;
          busy_cnt <= CW'(BUSY_CYCLES - 1);
`endif
        end else begin
          casez (lcd_data_in)
            8'b1???????: address   <= lcd_data_in[6:0];
            8'b001?????: two_line  <= lcd_data_in[3];
            8'b00001???: disp_on   <= lcd_data_in[2];
            8'b000001??: entry_inc <= lcd_data_in[1];
            8'b0000001?: address   <= 7'd0;
            8'b00000001: begin
              address   <= 7'd0;
              entry_inc <= 1'b1;
              clr_idx   <= 5'd0;
              state     <= CLEARING;
            end
            default: ;
          endcase
`ifdef LCD_RX_BUSY_EN
          if (lcd_data_in != 8'h01) begin
            state    <= BUSY;
            busy_cnt <= CW'(BUSY_CYCLES - 1);
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_receiver.sv
// Randomized bench for lcd_receiver against a behavioural display/cursor model.
module tb_lcd_receiver;
  logic       clk = 1'b0;
  logic       rst, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data_in, lcd_data_out, rd_char;
  logic       lcd_data_oe, disp_on, entry_inc, two_line, cmd_drop;
  logic [4:0] rd_addr;
  logic [6:0] cursor;

  int checks = 0, errors = 0;
  int drop_cnt = 0, exp_drop = 0;
  int m_buf [32];
  int m_addr;
  bit m_inc, m_two, m_disp;

`ifdef LCD_RX_BUSY_EN
  localparam int GAP = 45;
`else
  localparam int GAP = 0;
`endif

  lcd_receiver #(.BUSY_CYCLES(40)) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor), .disp_on(disp_on),
    .entry_inc(entry_inc), .two_line(two_line), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_drop === 1'b1) drop_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int map_idx(int a);
    if (a < 16) return a;
    if (a >= 'h40 && a < 'h50) return a - 'h40 + 16;
    return -1;
  endfunction

  function automatic int next_addr(int a);
    if (m_two) begin
      if (m_inc) return (a == 'h27) ? 'h40 : (a == 'h67) ? 0 : (a + 1) % 128;
      return (a == 'h40) ? 'h27 : (a == 0) ? 'h67 : a - 1;
    end
    if (m_inc) return (a + 1) % 'h50;
    return (a + 'h50 - 1) % 'h50;
  endfunction

  task automatic m_clear_buf();
    for (int i = 0; i < 32; i++) m_buf[i] = 'h20;
  endtask

  task automatic m_reset();
    m_clear_buf();
    m_addr = 0; m_inc = 1; m_disp = 0; m_two = 0;
  endtask

  // Called at a negedge; returns at the negedge where the strobe's effect is visible.
  task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, input int hi);
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_e = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_e = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rd(input bit rs, output logic [7:0] val, output logic oe);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    val = lcd_data_out; oe = lcd_data_oe;
    lcd_e = 1'b0;
    repeat (3) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic m_data(input logic [7:0] d);
    int idx;
    idx = map_idx(m_addr);
    if (idx >= 0) m_buf[idx] = d;
    m_addr = next_addr(m_addr);
  endtask

  task automatic wr(input bit rs, input logic [7:0] d);
    xfer(rs, 1'b0, d, 3);
    if (rs) m_data(d);
    else if (d[7]) m_addr = int'(d[6:0]);
    else if (d[6]) ;
    else if (d[5]) m_two = d[3];
    else if (d[4]) ;
    else if (d[3]) m_disp = d[2];
    else if (d[2]) m_inc = d[1];
    else if (d[1]) m_addr = 0;
    else if (d[0]) begin
      m_clear_buf(); m_addr = 0; m_inc = 1;
      repeat (34) @(negedge clk);
    end
    repeat (GAP) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    int a;
    check({tag, "_cursor"}, 32'(cursor), m_addr);
    check({tag, "_disp_on"}, 32'(disp_on), 32'(m_disp));
    check({tag, "_entry_inc"}, 32'(entry_inc), 32'(m_inc));
    check({tag, "_two_line"}, 32'(two_line), 32'(m_two));
    check({tag, "_drops"}, drop_cnt, exp_drop);
    a = $urandom_range(0, 31);
    rd_addr = a[4:0];
    #1;
    check({tag, "_rd_char"}, 32'(rd_char), m_buf[a]);
  endtask

  task automatic check_all_blank(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      if (rd_char !== 8'h20) bad++;
    end
    check({tag, "_nonblank_entries"}, bad, 0);
  endtask

  initial begin
    logic [7:0] r, v;
    logic oe;
    int op, idx;

    rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_in = 8'h00; rd_addr = 5'd0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_cursor", 32'(cursor), 0);
    check("rst_entry_inc", 32'(entry_inc), 1);
    check("rst_disp_on", 32'(disp_on), 0);
    check("rst_two_line", 32'(two_line), 0);
    check("rst_oe", 32'(lcd_data_oe), 0);
    check("rst_data_out", 32'(lcd_data_out), 0);
    check("rst_cmd_drop", 32'(cmd_drop), 0);
    check_all_blank("rst_buf");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Set DDRAM 0x00, write two characters
    wr(0, 8'h80); wr(1, 8'h48); wr(1, 8'h69);
    rd_addr = 5'd0; #1; check("hi_char0", 32'(rd_char), 'h48);
    rd_addr = 5'd1; #1; check("hi_char1", 32'(rd_char), 'h69);
    check("hi_cursor", 32'(cursor), 'h02);
    @(negedge clk);

`ifdef LCD_RX_BUSY_EN
    xfer(1, 1'b0, 8'h33, 3);
    m_data(8'h33);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_at_10", 32'(lcd_data_out[7]), 1);
    check("busy_at_10_oe", 32'(lcd_data_oe), 1);
    repeat (35) @(negedge clk);
    check("busy_at_45", 32'(lcd_data_out[7]), 0);
    lcd_e = 1'b0;
    repeat (3) @(negedge clk);
    lcd_rw = 1'b0;
    check_state("busy_after");
    @(negedge clk);
`endif

    // Two-line wrap at 0x27 skips the unmapped write and lands on 0x40
    wr(0, 8'h28); wr(0, 8'hA7); wr(1, 8'h41);
    check("wrap_cursor", 32'(cursor), 'h40);
    check_state("wrap");
    @(negedge clk);
    wr(1, 8'h42);
    rd_addr = 5'd16; #1; check("wrap_char16", 32'(rd_char), 'h42);
    @(negedge clk);

    // Decrement from 0x40 wraps back to 0x27
    wr(0, 8'h04); wr(0, 8'hC0); wr(1, 8'h5A);
    rd_addr = 5'd16; #1; check("dec_char16", 32'(rd_char), 'h5A);
    check("dec_cursor", 32'(cursor), 'h27);
    @(negedge clk);

    // Fill buffer, clear, and hit it with a write 5 clk into the clear
    wr(0, 8'h06); wr(0, 8'h80);
    for (int i = 0; i < 16; i++) wr(1, 8'h61 + 8'(i));
    wr(0, 8'hC0);
    for (int i = 0; i < 16; i++) wr(1, 8'h41 + 8'(i));
    check_state("filled");
    @(negedge clk);
    xfer(0, 1'b0, 8'h01, 3);
    xfer(1, 1'b0, 8'h55, 2);
    exp_drop++;
    m_clear_buf(); m_addr = 0; m_inc = 1;
    repeat (30 + GAP) @(negedge clk);
    check_all_blank("clear_buf");
    check("clear_cursor", 32'(cursor), 0);
    check_state("clear");
    @(negedge clk);

    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 10);
      r = 8'($urandom);
      case (op)
        0, 1, 2, 3: wr(1, r);
        4: wr(0, 8'h80 | r);
        5: wr(0, 8'h04 | {6'b0, r[1:0]});
        6: wr(0, 8'h20 | {3'b0, r[4:0]});
        7: wr(0, 8'h08 | {5'b0, r[2:0]});
        8: case (r[7:6])
             2'd0: wr(0, 8'h00);
             2'd1: wr(0, 8'h10 | {4'b0, r[3:0]});
             2'd2: wr(0, 8'h40 | {2'b0, r[5:0]});
             default: wr(0, 8'h02 | {7'b0, r[0]});
           endcase
        9: begin
          rd(1, v, oe);
          idx = map_idx(m_addr);
          check("rnd_data_read", 32'(v), (idx >= 0) ? m_buf[idx] : 'h20);
          check("rnd_data_read_oe", 32'(oe), 1);
          m_addr = next_addr(m_addr);
        end
        default: begin
          rd(0, v, oe);
          check("rnd_status", 32'(v), m_addr);
          check("rnd_status_oe", 32'(oe), 1);
        end
      endcase
      check_state("rnd");
      @(negedge clk);
      check("rnd_idle_oe", 32'(lcd_data_oe), 0);
      check("rnd_idle_out", 32'(lcd_data_out), 0);
    end

    // Reset in the middle of a clear, at index 12
    wr(0, 8'h0C); wr(0, 8'h28); wr(0, 8'h04); wr(0, 8'h85);
    wr(1, 8'h11);
    xfer(0, 1'b0, 8'h01, 3);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m_reset();
    check("mid_rst_cursor", 32'(cursor), 0);
    check("mid_rst_entry_inc", 32'(entry_inc), 1);
    check("mid_rst_disp_on", 32'(disp_on), 0);
    check("mid_rst_two_line", 32'(two_line), 0);
    check("mid_rst_oe", 32'(lcd_data_oe), 0);
    check("mid_rst_data_out", 32'(lcd_data_out), 0);
    check("mid_rst_cmd_drop", 32'(cmd_drop), 0);
    check_all_blank("mid_rst_buf");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(0, v, oe);
    check("post_rst_status", 32'(v), 0);
    wr(1, 8'h77);
    rd_addr = 5'd0; #1; check("post_rst_char0", 32'(rd_char), 'h77);
    check_state("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
